// File: rtl/scaler_dsp_feed.sv
// Horizontal scaler front end: tracks source position, builds 4-tap windows on two rows and feeds taps plus phase coefficients to a DSP unit.
// Optional build macro SCALER_DSP_FEED_EDGE_CLAMP_EN: out-of-range taps replicate the edge pixel instead of reading as zero.
module scaler_dsp_feed #(
  parameter int PIXEL_BITWIDTH       = 8,
  parameter int KERNEL_MAX           = 4,
  parameter int KERNEL_COEF_BITWIDTH = 8,
  parameter int PHASE_BITWIDTH       = 4,
  parameter int FRAC_BITWIDTH        = 12,
  parameter int WIDTH_BITWIDTH       = 12
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_start,
  input  logic [WIDTH_BITWIDTH-1:0]                      cfg_in_width,
  input  logic [WIDTH_BITWIDTH-1:0]                      cfg_out_width,
  input  logic [WIDTH_BITWIDTH+FRAC_BITWIDTH-1:0]        cfg_step,
  input  logic                                           s_valid,
  output logic                                           s_ready,
  input  logic [PIXEL_BITWIDTH-1:0]                      s_pixel_1,
  input  logic [PIXEL_BITWIDTH-1:0]                      s_pixel_2,
  input  logic                                           coef_wr_en,
  input  logic [PHASE_BITWIDTH-1:0]                      coef_wr_addr,
  input  logic [KERNEL_MAX*KERNEL_COEF_BITWIDTH-1:0]     coef_wr_data,
  output logic                                           dout_en,
  output logic [KERNEL_MAX*KERNEL_COEF_BITWIDTH-1:0]     dout_coef,
  output logic [KERNEL_MAX*PIXEL_BITWIDTH-1:0]           dout_pixel_1,
  output logic [KERNEL_MAX*PIXEL_BITWIDTH-1:0]           dout_pixel_2,
  output logic                                           busy,
  output logic                                           done
);

  localparam int POS_W = WIDTH_BITWIDTH + FRAC_BITWIDTH;
  localparam int CW    = KERNEL_MAX * KERNEL_COEF_BITWIDTH;
  localparam int PW    = KERNEL_MAX * PIXEL_BITWIDTH;
  localparam int HW    = WIDTH_BITWIDTH + 1;
  localparam int DEPTH = 1 << PHASE_BITWIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t                     state_reg;
  logic [WIDTH_BITWIDTH-1:0]  in_width_reg;
  logic [WIDTH_BITWIDTH-1:0]  out_width_reg;
  logic [POS_W-1:0]           step_reg;
  logic [POS_W-1:0]           pos_reg;
  logic [HW-1:0]              h_reg;
  logic [WIDTH_BITWIDTH-1:0]  beat_cnt_reg;
  logic [WIDTH_BITWIDTH-1:0]  emit_cnt_reg;
  logic                       busy_reg;
  logic                       done_reg;

  logic [PIXEL_BITWIDTH-1:0]  win1_reg [KERNEL_MAX];
  logic [PIXEL_BITWIDTH-1:0]  win2_reg [KERNEL_MAX];
  logic [PW-1:0]              win1_packed;
  logic [PW-1:0]              win2_packed;

  logic                       en_pipe_reg;
  logic [PW-1:0]              pix1_pipe_reg;
  logic [PW-1:0]              pix2_pipe_reg;
  logic [CW-1:0]              coef_mem [DEPTH];
  logic [CW-1:0]              coef_rd_reg;

  logic                       dout_en_reg;
  logic [CW-1:0]              dout_coef_reg;
  logic [PW-1:0]              dout_pix1_reg;
  logic [PW-1:0]              dout_pix2_reg;

  logic [HW-1:0]              x_ext;
  logic [HW-1:0]              target;
  logic [HW-1:0]              in_last;
  logic                       in_run;
  logic                       emit;
  logic                       want_adv;
  logic                       need_input;
  logic                       run_take;
  logic                       load_take;
  logic                       flush_take;
  logic                       beat;
  logic                       load_fire;
  logic                       adv_fire;
  logic                       last_emit;
  logic                       flush_end;
  logic [PHASE_BITWIDTH-1:0]  phase;
  logic [PIXEL_BITWIDTH-1:0]  left_fill1;
  logic [PIXEL_BITWIDTH-1:0]  left_fill2;
  logic [PIXEL_BITWIDTH-1:0]  edge1;
  logic [PIXEL_BITWIDTH-1:0]  edge2;
  logic [PIXEL_BITWIDTH-1:0]  in1;
  logic [PIXEL_BITWIDTH-1:0]  in2;

  // The window trails the position: an output for x needs source indices x-1..x+2.
  assign x_ext      = {1'b0, pos_reg[POS_W-1:FRAC_BITWIDTH]};
  assign target     = x_ext + HW'(2);
  assign in_last    = {1'b0, in_width_reg} - HW'(1);
  assign in_run     = (state_reg == ST_RUN);
  assign emit       = in_run && (h_reg == target);
  assign want_adv   = in_run && (h_reg < target);
  assign need_input = (h_reg < in_last);
  assign run_take   = want_adv && need_input;
  assign load_take  = (state_reg == ST_LOAD);
  assign flush_take = (state_reg == ST_FLUSH) && (beat_cnt_reg < in_width_reg);
  assign s_ready    = run_take || load_take || flush_take;
  assign beat       = s_valid && s_ready;
  assign load_fire  = load_take && s_valid;
  assign adv_fire   = want_adv && (!need_input || s_valid);
  assign last_emit  = (emit_cnt_reg == out_width_reg - WIDTH_BITWIDTH'(1));
  assign flush_end  = (state_reg == ST_FLUSH) && (beat_cnt_reg == in_width_reg) && !en_pipe_reg;
  assign phase      = pos_reg[FRAC_BITWIDTH-1 -: PHASE_BITWIDTH];

`ifdef SCALER_DSP_FEED_EDGE_CLAMP_EN
  assign left_fill1 = s_pixel_1;
  assign left_fill2 = s_pixel_2;
  assign edge1      = win1_reg[KERNEL_MAX-1];
  assign edge2      = win2_reg[KERNEL_MAX-1];
`else
  assign left_fill1 = '0;
  assign left_fill2 = '0;
  assign edge1      = '0;
  assign edge2      = '0;
`endif

  // Past the last source pixel the top tap keeps repeating the edge value.
  assign in1 = need_input ? s_pixel_1 : edge1;
  assign in2 = need_input ? s_pixel_2 : edge2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      in_width_reg  <= '0;
      out_width_reg <= '0;
      step_reg      <= '0;
      pos_reg       <= '0;
      h_reg         <= '0;
      beat_cnt_reg  <= '0;
      emit_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (beat) begin
        beat_cnt_reg <= beat_cnt_reg + WIDTH_BITWIDTH'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (cfg_start) begin
            in_width_reg  <= cfg_in_width;
            out_width_reg <= cfg_out_width;
            step_reg      <= cfg_step;
            pos_reg       <= '0;
            h_reg         <= '0;
            beat_cnt_reg  <= '0;
            emit_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            h_reg     <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (emit) begin
            pos_reg      <= pos_reg + step_reg;
            emit_cnt_reg <= emit_cnt_reg + WIDTH_BITWIDTH'(1);
            if (last_emit) begin
              state_reg <= ST_FLUSH;
            end
          end else if (adv_fire) begin
            h_reg <= h_reg + HW'(1);
          end
        end
        ST_FLUSH: begin
          // Wait for the final output to leave the pipeline before signalling the end of line.
          if (flush_end) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_MAX; gi++) begin : g_tap
      if (gi == KERNEL_MAX - 1) begin : g_top
        always_ff @(posedge clk) begin
          if (rst) begin
            win1_reg[gi] <= '0;
            win2_reg[gi] <= '0;
          end else if (load_fire) begin
            win1_reg[gi] <= s_pixel_1;
            win2_reg[gi] <= s_pixel_2;
          end else if (adv_fire) begin
            win1_reg[gi] <= in1;
            win2_reg[gi] <= in2;
          end
        end
      end else begin : g_low
        always_ff @(posedge clk) begin
          if (rst) begin
            win1_reg[gi] <= '0;
            win2_reg[gi] <= '0;
          end else if (load_fire) begin
            win1_reg[gi] <= left_fill1;
            win2_reg[gi] <= left_fill2;
          end else if (adv_fire) begin
            win1_reg[gi] <= win1_reg[gi+1];
            win2_reg[gi] <= win2_reg[gi+1];
          end
        end
      end
      assign win1_packed[gi*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = win1_reg[gi];
      assign win2_packed[gi*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = win2_reg[gi];
    end
  endgenerate

  // Read-before-write table: a same-cycle write to the read address returns the old entry.
  always_ff @(posedge clk) begin
    if (coef_wr_en) begin
      coef_mem[coef_wr_addr] <= coef_wr_data;
    end
    coef_rd_reg <= coef_mem[phase];
  end

  always_ff @(posedge clk) begin
    if (emit) begin
      pix1_pipe_reg <= win1_packed;
      pix2_pipe_reg <= win2_packed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_pipe_reg   <= 1'b0;
      dout_en_reg   <= 1'b0;
      dout_coef_reg <= '0;
      dout_pix1_reg <= '0;
      dout_pix2_reg <= '0;
    end else begin
      en_pipe_reg <= emit;
      dout_en_reg <= en_pipe_reg;
      if (en_pipe_reg) begin
        dout_coef_reg <= coef_rd_reg;
        dout_pix1_reg <= pix1_pipe_reg;
        dout_pix2_reg <= pix2_pipe_reg;
      end
    end
  end

  assign dout_en      = dout_en_reg;
  assign dout_coef    = dout_coef_reg;
  assign dout_pixel_1 = dout_pix1_reg;
  assign dout_pixel_2 = dout_pix2_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_scaler_dsp_feed.sv
// Scoreboard bench for scaler_dsp_feed: directed lines push expected tap vectors, a monitor pops them on every dout_en.
module tb_scaler_dsp_feed;

  localparam int PB = 8;
  localparam int KM = 4;
  localparam int CB = 8;
  localparam int PH = 4;
  localparam int FB = 12;
  localparam int WB = 12;

`ifdef SCALER_DSP_FEED_EDGE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic [WB-1:0]     cfg_in_width;
  logic [WB-1:0]     cfg_out_width;
  logic [WB+FB-1:0]  cfg_step;
  logic              s_valid;
  logic              s_ready;
  logic [PB-1:0]     s_pixel_1;
  logic [PB-1:0]     s_pixel_2;
  logic              coef_wr_en;
  logic [PH-1:0]     coef_wr_addr;
  logic [KM*CB-1:0]  coef_wr_data;
  logic              dout_en;
  logic [KM*CB-1:0]  dout_coef;
  logic [KM*PB-1:0]  dout_pixel_1;
  logic [KM*PB-1:0]  dout_pixel_2;
  logic              busy;
  logic              done;

  scaler_dsp_feed #(
    .PIXEL_BITWIDTH(PB), .KERNEL_MAX(KM), .KERNEL_COEF_BITWIDTH(CB),
    .PHASE_BITWIDTH(PH), .FRAC_BITWIDTH(FB), .WIDTH_BITWIDTH(WB)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_in_width(cfg_in_width),
    .cfg_out_width(cfg_out_width), .cfg_step(cfg_step), .s_valid(s_valid),
    .s_ready(s_ready), .s_pixel_1(s_pixel_1), .s_pixel_2(s_pixel_2),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .dout_en(dout_en), .dout_coef(dout_coef), .dout_pixel_1(dout_pixel_1),
    .dout_pixel_2(dout_pixel_2), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] coef;
    logic [31:0] p1;
    logic [31:0] p2;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          out_idx  = 0;
  logic [7:0]  pix_tb [8];
  logic [31:0] c0;
  logic [31:0] c8;

  function automatic logic [31:0] taps(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    chk_cnt++;
    if (act !== req) $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    else pass_cnt++;
  endtask

  // Row 2 always carries row 1 divided by ten, so its expected taps follow directly.
  task automatic push(input logic [31:0] c, input int a, input int b, input int cc, input int d);
    exp_q.push_back({c, taps(a, b, cc, d), taps(a / 10, b / 10, cc / 10, d / 10)});
  endtask

  always @(negedge clk) begin
    if (dout_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_dout: actual dout_en=1 coef=%0h pix1=%0h, required no output", dout_coef, dout_pixel_1);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("dout%0d", out_idx), {dout_coef, dout_pixel_1, dout_pixel_2}, mon_e);
        $display("out %0d: coef=%08h pix1=%08h pix2=%08h", out_idx, dout_coef, dout_pixel_1, dout_pixel_2);
      end
      out_idx++;
    end
  end

  task automatic wr_coef(input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    coef_wr_en   = 1'b1;
    coef_wr_addr = addr[PH-1:0];
    coef_wr_data = data;
    @(posedge clk); #1;
    coef_wr_en   = 1'b0;
  endtask

  task automatic start_line(input int in_w, input int out_w, input logic [23:0] step);
    @(posedge clk); #1;
    cfg_start     = 1'b1;
    cfg_in_width  = in_w[WB-1:0];
    cfg_out_width = out_w[WB-1:0];
    cfg_step      = step;
    @(posedge clk); #1;
    cfg_start     = 1'b0;
    cfg_in_width  = 12'd1;
    cfg_out_width = 12'd1;
    cfg_step      = 24'h007000;
    @(negedge clk);
    check("busy_after_start", 96'(busy), 96'd1);
  endtask

  task automatic run_line(input string name, input int in_w, input int out_w, input logic [23:0] step,
                          input int period, input int avail);
    int  acc = 0;
    bit  done_seen = 1'b0;
    start_line(in_w, out_w, step);
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(posedge clk); #1;
      cfg_start = (cyc == 3);
      s_valid   = (acc < avail) && ((cyc % period) == 0);
      s_pixel_1 = (acc < 8) ? pix_tb[acc] : 8'd0;
      s_pixel_2 = s_pixel_1 / 8'd10;
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      if (done) done_seen = 1'b1;
    end
    @(posedge clk); #1;
    s_valid   = 1'b0;
    cfg_start = 1'b0;
    check({name, "_done_seen"}, 96'(done_seen), 96'd1);
    check({name, "_beats"}, 96'(acc), 96'(in_w));
    check({name, "_outs_left"}, 96'(exp_q.size()), 96'd0);
    @(negedge clk);
    check({name, "_idle"}, {94'd0, busy, done}, 96'd0);
    $display("line %s: beats=%0d done=%0d", name, acc, done_seen);
  endtask

  task automatic push_basic();
    int lf = CLAMP ? 10 : 0;
    int rf = CLAMP ? 40 : 0;
    push(c0, lf, 10, 20, 30);
    push(c0, 10, 20, 30, 40);
    push(c0, 20, 30, 40, rf);
    push(c0, 30, 40, rf, rf);
  endtask

  task automatic set_pix(input int base, input int inc);
    for (int i = 0; i < 8; i++) pix_tb[i] = 8'(base + inc * i);
  endtask

  int en_cnt;
  int acc_r;
  bit late_done;
  int lf;
  int rf;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_in_width = '0; cfg_out_width = '0; cfg_step = '0;
    s_valid = 1'b0; s_pixel_1 = '0; s_pixel_2 = '0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    c0 = taps(0, 64, 0, 0);
    c8 = taps(16, 48, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {dout_en, busy, done, s_ready, dout_coef, dout_pixel_1, dout_pixel_2}, 100'd0);

    for (int a = 0; a < 16; a++) wr_coef(a, 32'h11111111 * a + 32'h01020304);
    wr_coef(0, c0);
    wr_coef(8, c8);

    // Unit step, continuous input.
    set_pix(10, 10);
    push_basic();
    run_line("unit_step", 4, 4, 24'h001000, 1, 4);

    // Same line with input valid one cycle in three.
    push_basic();
    run_line("sparse_valid", 4, 4, 24'h001000, 3, 4);

    // Half step: two source pixels, four outputs, phases 0 and 8 alternate.
    pix_tb[0] = 8'd10; pix_tb[1] = 8'd20; pix_tb[2] = 8'd90; pix_tb[3] = 8'd90;
    lf = CLAMP ? 10 : 0;
    rf = CLAMP ? 20 : 0;
    push(c0, lf, 10, 20, rf);
    push(c8, lf, 10, 20, rf);
    push(c0, 10, 20, rf, rf);
    push(c8, 10, 20, rf, rf);
    run_line("half_step", 2, 4, 24'h000800, 1, 4);

    // Double step: two outputs, remaining beats flushed.
    set_pix(10, 10);
    lf = CLAMP ? 10 : 0;
    push(c0, lf, 10, 20, 30);
    push(c0, 20, 30, 40, 50);
    run_line("double_step", 8, 2, 24'h002000, 1, 8);

    // Reset after the second output aborts the line.
    set_pix(10, 10);
    push_basic();
    start_line(4, 4, 24'h001000);
    en_cnt = 0;
    acc_r  = 0;
    for (int cyc = 0; cyc < 200 && en_cnt < 2; cyc++) begin
      @(posedge clk); #1;
      s_valid   = (acc_r < 4);
      s_pixel_1 = pix_tb[acc_r % 8];
      s_pixel_2 = s_pixel_1 / 8'd10;
      @(negedge clk);
      if (s_valid && s_ready) acc_r++;
      if (dout_en) en_cnt++;
    end
    check("reset_seen_two_outs", 96'(en_cnt), 96'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("mid_line_reset", {dout_en, busy, done, s_ready, dout_coef, dout_pixel_1, dout_pixel_2}, 100'd0);
    exp_q.delete();
    late_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) late_done = 1'b1;
    end
    check("no_done_after_reset", 96'(late_done), 96'd0);

    push_basic();
    run_line("after_reset", 4, 4, 24'h001000, 1, 4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
